// File: rtl/cfu_ram_arbiter.sv
// Round-robin arbiter sharing the CFU Wishbone read port between the image
// fetcher (port 0) and the filter preload engine (port 1), with retry on error/timeout.
module cfu_ram_arbiter #(
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [29:0] req0_adr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [29:0] req1_adr,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        rsp1_err,
    output logic [29:0] cfu_ram_adr,
    output logic        cfu_ram_cyc,
    output logic        cfu_ram_stb,
    output logic        cfu_ram_we,
    output logic [3:0]  cfu_ram_sel,
    output logic [2:0]  cfu_ram_cti,
    output logic [1:0]  cfu_ram_bte,
    output logic [31:0] cfu_ram_dat_mosi,
    input  logic [31:0] cfu_ram_dat_miso,
    input  logic        cfu_ram_ack,
    input  logic        cfu_ram_err
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BACKOFF, RESP} state_t;

    state_t          state;
    logic            owner;
    logic            last_grant;
    logic            cyc;
    logic [TW-1:0]   tmo_cnt;
    logic [RW-1:0]   retry_cnt;
    logic            grant0;
    logic            grant1;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant0 = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
        grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready       = grant0;
    assign req1_ready       = grant1;
    assign cfu_ram_cyc      = cyc;
    assign cfu_ram_stb      = cyc;
    assign cfu_ram_we       = 1'b0;
    assign cfu_ram_sel      = 4'b1111;
    assign cfu_ram_cti      = 3'b000;
    assign cfu_ram_bte      = 2'b00;
    assign cfu_ram_dat_mosi = 32'h0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cyc         <= 1'b0;
            cfu_ram_adr <= '0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
            rsp0_valid  <= 1'b0;
            rsp0_data   <= '0;
            rsp0_err    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_data   <= '0;
            rsp1_err    <= 1'b0;
        end else begin
            // Response signals are a single-cycle pulse unless set below.
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner       <= grant1;
                        last_grant  <= grant1;
                        cfu_ram_adr <= grant1 ? req1_adr : req0_adr;
                        retry_cnt   <= '0;
                        tmo_cnt     <= '0;
                        cyc         <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cfu_ram_ack && !cfu_ram_err) begin
                        cyc   <= 1'b0;
                        state <= RESP;
                        if (owner) begin
                            rsp1_valid <= 1'b1;
                            rsp1_data  <= cfu_ram_dat_miso;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_data  <= cfu_ram_dat_miso;
                        end
                    end else if (cfu_ram_err || tmo_cnt == TW'(TIMEOUT - 1)) begin
                        cyc <= 1'b0;
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            tmo_cnt   <= '0;
                            state     <= BACKOFF;
                        end else begin
                            state <= RESP;
                            if (owner) begin
                                rsp1_valid <= 1'b1;
                                rsp1_err   <= 1'b1;
                            end else begin
                                rsp0_valid <= 1'b1;
                                rsp0_err   <= 1'b1;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                BACKOFF: begin
                    cyc   <= 1'b1;
                    state <= ISSUE;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cfu_ram_arbiter.sv
// Directed bench for cfu_ram_arbiter with TIMEOUT=4, MAX_RETRY=3; a hand-driven
// slave runs every scenario from one linear initial block.
module tb_cfu_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [29:0] req0_adr, req1_adr;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err;
    logic [29:0] cfu_ram_adr;
    logic        cfu_ram_cyc, cfu_ram_stb, cfu_ram_we;
    logic [3:0]  cfu_ram_sel;
    logic [2:0]  cfu_ram_cti;
    logic [1:0]  cfu_ram_bte;
    logic [31:0] cfu_ram_dat_mosi, cfu_ram_dat_miso;
    logic        cfu_ram_ack, cfu_ram_err;

    int total = 0;
    int bad   = 0;

    cfu_ram_arbiter #(.TIMEOUT(4), .MAX_RETRY(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_adr(req0_adr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_adr(req1_adr), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .cfu_ram_adr(cfu_ram_adr), .cfu_ram_cyc(cfu_ram_cyc), .cfu_ram_stb(cfu_ram_stb),
        .cfu_ram_we(cfu_ram_we), .cfu_ram_sel(cfu_ram_sel), .cfu_ram_cti(cfu_ram_cti),
        .cfu_ram_bte(cfu_ram_bte), .cfu_ram_dat_mosi(cfu_ram_dat_mosi),
        .cfu_ram_dat_miso(cfu_ram_dat_miso), .cfu_ram_ack(cfu_ram_ack), .cfu_ram_err(cfu_ram_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [29:0] a0,
                                 input logic v1, input logic [29:0] a1);
        req0_valid = v0;
        req0_adr   = a0;
        req1_valid = v1;
        req1_adr   = a1;
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        cfu_ram_ack = 1'b0;
        cfu_ram_err = 1'b0;
        cfu_ram_dat_miso = 32'h0;
        applyStimulus(1'b0, 30'h0, 1'b0, 30'h0);
        doReset();

        checkOutput("rst_cyc", 32'(cfu_ram_cyc), 32'd0);
        checkOutput("rst_adr", 32'(cfu_ram_adr), 32'd0);
        checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        checkOutput("rst_consts", {cfu_ram_we, cfu_ram_sel, cfu_ram_cti, cfu_ram_bte, cfu_ram_dat_mosi[21:0]}, {1'b0, 4'hF, 3'd0, 2'd0, 22'd0});

        // Alternating grants on a continuous tie, zero-wait slave.
        applyStimulus(1'b1, 30'h200, 1'b1, 30'h300);
        for (int i = 0; i < 4; i++) begin
            checkOutput("tie_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("tie_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            checkOutput("tie_cyc", 32'(cfu_ram_cyc), 32'd1);
            checkOutput("tie_adr", 32'(cfu_ram_adr), (i % 2 == 0) ? 32'h200 : 32'h300);
            checkOutput("tie_ready_busy", 32'({req0_ready, req1_ready}), 32'd0);
            cfu_ram_ack = 1'b1;
            cfu_ram_dat_miso = 32'hA000_0000 + 32'(i);
            tick();
            cfu_ram_ack = 1'b0;
            checkOutput("tie_cyc_low", 32'(cfu_ram_cyc), 32'd0);
            checkOutput("tie_rsp0_valid", 32'(rsp0_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("tie_rsp1_valid", 32'(rsp1_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput("tie_data", (i % 2 == 0) ? rsp0_data : rsp1_data, 32'hA000_0000 + 32'(i));
            checkOutput("tie_other_data", (i % 2 == 0) ? rsp1_data : rsp0_data, 32'd0);
            tick();
        end
        applyStimulus(1'b0, 30'h0, 1'b0, 30'h0);

        // Single read on port 0 with two wait states.
        applyStimulus(1'b1, 30'h100, 1'b0, 30'h0);
        checkOutput("p0_ready", 32'(req0_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 30'h0, 1'b0, 30'h0);
        for (int w = 0; w < 3; w++) begin
            checkOutput("p0_cyc", 32'(cfu_ram_cyc & cfu_ram_stb), 32'd1);
            checkOutput("p0_adr", 32'(cfu_ram_adr), 32'h100);
            checkOutput("p0_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
            if (w == 2) begin
                cfu_ram_ack = 1'b1;
                cfu_ram_dat_miso = 32'hDEADBEEF;
            end
            tick();
        end
        cfu_ram_ack = 1'b0;
        checkOutput("p0_rsp_valid", 32'(rsp0_valid), 32'd1);
        checkOutput("p0_rsp_data", rsp0_data, 32'hDEADBEEF);
        checkOutput("p0_rsp_err", 32'(rsp0_err), 32'd0);
        checkOutput("p0_rsp1_quiet", 32'(rsp1_valid), 32'd0);
        checkOutput("p0_cyc_done", 32'(cfu_ram_cyc), 32'd0);
        tick();
        checkOutput("p0_pulse_once", 32'(rsp0_valid), 32'd0);

        // Two errors then an ack on port 1.
        applyStimulus(1'b0, 30'h0, 1'b1, 30'h3AB);
        checkOutput("err_ready1", 32'(req1_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 30'h0, 1'b0, 30'h0);
        for (int a = 0; a < 2; a++) begin
            checkOutput("err_cyc_hi", 32'(cfu_ram_cyc), 32'd1);
            checkOutput("err_adr", 32'(cfu_ram_adr), 32'h3AB);
            cfu_ram_err = 1'b1;
            tick();
            cfu_ram_err = 1'b0;
            checkOutput("err_backoff_low", 32'(cfu_ram_cyc), 32'd0);
            checkOutput("err_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
            tick();
        end
        checkOutput("err_third_cyc", 32'(cfu_ram_cyc), 32'd1);
        checkOutput("err_third_adr", 32'(cfu_ram_adr), 32'h3AB);
        cfu_ram_ack = 1'b1;
        cfu_ram_dat_miso = 32'h12345678;
        tick();
        cfu_ram_ack = 1'b0;
        checkOutput("err_rsp1_valid", 32'(rsp1_valid), 32'd1);
        checkOutput("err_rsp1_data", rsp1_data, 32'h12345678);
        checkOutput("err_rsp1_err", 32'(rsp1_err), 32'd0);
        checkOutput("err_rsp0_quiet", 32'(rsp0_valid), 32'd0);
        tick();

        // Silent slave: four attempts of four cycles each, then an error response.
        applyStimulus(1'b1, 30'h0FF, 1'b0, 30'h0);
        tick();
        applyStimulus(1'b0, 30'h0, 1'b0, 30'h0);
        for (int a = 0; a < 4; a++) begin
            for (int c = 0; c < 4; c++) begin
                checkOutput("tmo_cyc_hi", 32'(cfu_ram_cyc), 32'd1);
                tick();
            end
            checkOutput("tmo_cyc_low", 32'(cfu_ram_cyc), 32'd0);
            if (a < 3) begin
                checkOutput("tmo_no_rsp", 32'(rsp0_valid), 32'd0);
                tick();
            end
        end
        checkOutput("tmo_rsp_valid", 32'(rsp0_valid), 32'd1);
        checkOutput("tmo_rsp_err", 32'(rsp0_err), 32'd1);
        checkOutput("tmo_rsp_data", rsp0_data, 32'd0);
        tick();

        // Ack together with err counts as an error.
        applyStimulus(1'b0, 30'h0, 1'b1, 30'h055);
        tick();
        applyStimulus(1'b0, 30'h0, 1'b0, 30'h0);
        cfu_ram_ack = 1'b1;
        cfu_ram_err = 1'b1;
        cfu_ram_dat_miso = 32'hBAD0BAD0;
        tick();
        cfu_ram_ack = 1'b0;
        cfu_ram_err = 1'b0;
        checkOutput("ackerr_no_rsp", 32'(rsp1_valid), 32'd0);
        checkOutput("ackerr_backoff", 32'(cfu_ram_cyc), 32'd0);
        tick();
        checkOutput("ackerr_retry_cyc", 32'(cfu_ram_cyc), 32'd1);
        cfu_ram_ack = 1'b1;
        cfu_ram_dat_miso = 32'h0000_0055;
        tick();
        cfu_ram_ack = 1'b0;
        checkOutput("ackerr_rsp_valid", 32'(rsp1_valid), 32'd1);
        checkOutput("ackerr_rsp_data", rsp1_data, 32'h0000_0055);
        tick();

        // Stray ack while idle.
        cfu_ram_ack = 1'b1;
        tick();
        tick();
        checkOutput("stray_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        checkOutput("stray_no_cyc", 32'(cfu_ram_cyc), 32'd0);
        cfu_ram_ack = 1'b0;

        // Reset in the middle of an ISSUE on port 0 drops the cycle.
        applyStimulus(1'b1, 30'h1A0, 1'b0, 30'h0);
        tick();
        applyStimulus(1'b0, 30'h0, 1'b0, 30'h0);
        checkOutput("mid_cyc", 32'(cfu_ram_cyc), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("mid_cyc_drop", 32'(cfu_ram_cyc), 32'd0);
        cfu_ram_ack = 1'b1;
        tick();
        cfu_ram_ack = 1'b0;
        checkOutput("mid_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        applyStimulus(1'b1, 30'h1B0, 1'b1, 30'h2B0);
        checkOutput("mid_ready0", 32'(req0_ready), 32'd1);
        checkOutput("mid_ready1", 32'(req1_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 30'h0, 1'b0, 30'h0);
        checkOutput("mid_adr", 32'(cfu_ram_adr), 32'h1B0);
        cfu_ram_ack = 1'b1;
        cfu_ram_dat_miso = 32'hCAFE0001;
        tick();
        cfu_ram_ack = 1'b0;
        checkOutput("mid_rsp0", 32'(rsp0_valid), 32'd1);
        checkOutput("mid_rsp0_data", rsp0_data, 32'hCAFE0001);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
